// File: rtl/approx_mult_seq.sv
// Iterative segmented multiplier: accumulates one SEG x SEG segment product per cycle,
// either diagonal terms only (approximate) or every segment pair (exact).
module approx_mult_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEG   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    // WIDTH is expected to be a multiple of SEG.
    localparam int unsigned NSEG = WIDTH / SEG;
    localparam int unsigned IW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned TW   = 2 * SEG;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSEG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_mode;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_p;
    logic [IW-1:0]     r_i;
    logic [IW-1:0]     r_j;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [SEG-1:0]    w_a_seg;
    logic [SEG-1:0]    w_b_seg;
    logic [TW-1:0]     w_prod;
    logic [PW-1:0]     w_term;
    logic [PW-1:0]     w_sum;
    logic              w_last;

    // Current term (i,j), placed at its binary weight in the accumulator.
    assign w_a_seg = SEG'(r_a >> (SEG * 32'(r_i)));
    assign w_b_seg = SEG'(r_b >> (SEG * 32'(r_j)));
    assign w_prod  = TW'(w_a_seg) * TW'(w_b_seg);
    assign w_term  = PW'(w_prod) << (SEG * (32'(r_i) + 32'(r_j)));
    assign w_sum   = r_acc + w_term;

    // Approximate mode walks i==j, so only i decides the end of the diagonal.
    assign w_last  = (r_i == LAST_IDX) && (!r_mode || (r_j == LAST_IDX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= 1'b0;
            r_acc       <= '0;
            r_p         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_mode     <= mode;
                        r_acc      <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_p         <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (!r_mode) begin
                        r_i <= r_i + IW'(1);
                        r_j <= r_j + IW'(1);
                    end else if (r_j == LAST_IDX) begin
                        r_j <= '0;
                        r_i <= r_i + IW'(1);
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_p;
    assign busy      = r_busy;

endmodule

// File: doc/approx_mult_seq.md
# approx_mult_seq

Parametrised, iterative segmented multiplier. It generalises the team's fixed 4x4 diagonal-partial-product approximate multiplier to any WIDTH and segment size SEG. A runtime mode selects approximate (diagonal segment products only) or exact (all segment products). One segment product is accumulated per cycle. Operands enter and results leave over valid/ready handshakes, so the block can sit between pipeline stages of the datapath.

## Interface
- WIDTH, 8, operand width in bits; must be divisible by SEG.
- SEG, 2, segment width in bits; NSEG = WIDTH/SEG segments per operand.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- mode  input  1  0 = approximate (i==j pairs only), 1 = exact (all i,j pairs).
- out_valid  output  1  result valid on p.
- out_ready  input  1  downstream accepts result.
- p  output  2*WIDTH  product, unsigned.
- busy  output  1  high in CALC or DONE.

## Operation
- Segment k of x is x[SEG*k +: SEG], with k=0 as the LSB segment.
- Term(i,j) = a_seg[i]*b_seg[j] (2*SEG bits), zero-extended and shifted left by SEG*(i+j) into a 2*WIDTH accumulator.
- Approximate result = sum of Term(i,i) for i=0..NSEG-1. Exact result = sum over all i,j, which equals a*b.
- No truncation. The accumulator is 2*WIDTH bits and can never overflow in either mode.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and mode, clear acc, set i=j=0, go to CALC.
  - CALC: each cycle, acc += Term(i,j) and the index advances.
    - Approximate: i=j, incrementing together. Last term is i=NSEG-1.
    - Exact: j is the inner loop, i the outer. Last term is (NSEG-1,NSEG-1).
    - On the cycle the last term is added, go to DONE and load p with the final sum.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- mode, a and b are sampled only at acceptance. Changes during CALC or DONE have no effect.
- in_ready=0 in CALC and DONE. in_valid in those states is ignored and not queued.
- p holds its value from the DONE load until the next DONE load. It stays stable for the whole time out_valid is high.
- SEG==WIDTH: NSEG=1, and both modes give the exact product in one CALC cycle.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, busy=0, p=0, acc=0, i=j=0.
- Cycle counts:
  - Acceptance edge at t. CALC occupies edges t+1..t+C, where C=NSEG (approximate) or NSEG² (exact).
  - out_valid is high from after edge t+C.
  - Defaults: C=4 approximate, C=16 exact.
- With out_ready held high, out_valid lasts exactly one cycle and IDLE is re-entered after edge t+C+1. Minimum issue interval is C+2 cycles.
- Backpressure: with out_ready low, the block stays in DONE indefinitely. out_valid and p are stable and in_ready stays 0.
- Reset mid-operation: rst_n low at any edge forces IDLE, clears out_valid, p and acc, and drops the in-flight operation. The first acceptance is possible on the first edge with rst_n high.
- in_valid asserted during reset is not accepted.

## Test plan
1. Default params, a=0xFF, b=0xFF, mode=0 -> p=0x9999, out_valid 4 cycles after acceptance. Same operands with mode=1 -> p=0xFE01 after 16 cycles.
2. a=0x12, b=0x34: mode=0 -> p=0x0300; mode=1 -> p=0x03A8. Randomised 10k operands with mode=1 -> p==a*b every time.
3. WIDTH=4, SEG=2, a=0xB, b=0x6, mode=0 -> p=0x26 after 2 cycles. This matches the legacy 4x4 approximation. Sweep all 256 pairs against the diagonal model.
4. Hold out_ready=0 for 5 cycles after out_valid, toggling in_valid, a and mode -> p and out_valid stable, in_ready=0, nothing accepted. Release -> one transfer, then in_ready=1.
5. Assert rst_n=0 for one cycle in the middle of CALC (exact mode) -> next cycle in_ready=1, out_valid=0, p=0. A new operand a=3, b=5, mode=1 then yields p=15.
6. Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly C+2 cycles apart, with correct results in order.
